clkgen_prog_ctrl: RTL and testbench

Sequencer that reprograms the M/D ratio of a Spartan-6 `DCM_CLKGEN` at run time, which moves the cores' generated clock to a new frequency. It accepts a frequency-change request through a valid/ready handshake and range-checks M and D. It then shifts the LoadD, LoadM and GO words out on PROGEN/PROGDATA, waits for PROGDONE and for LOCKED to return. On lock loss it resets the DCM and retries. It sits in the clocks block next to the clock management tile, between the host-command decoder and the `DCM_CLKGEN` primitive.

---
 rtl/clkgen_prog_ctrl_if.sv | 16 +
 rtl/clkgen_prog_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_clkgen_prog_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/clkgen_prog_ctrl_if.sv
// clkgen_prog_ctrl_if
//   Frequency-change request channel between the host-command decoder and
//   the DCM_CLKGEN programming sequencer.
//   req_valid : request strobe (master -> slave)
//   req_m     : raw multiplier M, 9 bits (master -> slave)
//   req_d     : raw divider D, 9 bits (master -> slave)
//   req_ready : sequencer idle, request will be taken (slave -> master)
interface clkgen_prog_ctrl_if;
    logic       req_valid;
    logic [8:0] req_m;
    logic [8:0] req_d;
    logic       req_ready;

    modport master (output req_valid, req_m, req_d, input req_ready);
    modport slave  (input req_valid, req_m, req_d, output req_ready);
endinterface

// File: rtl/clkgen_prog_ctrl.sv
// clkgen_prog_ctrl
//   Reprograms the M/D ratio of a Spartan-6 DCM_CLKGEN at run time. A
//   request is range-checked, then the LoadD, LoadM and GO words are shifted
//   out on PROGEN/PROGDATA. The block then waits for PROGDONE and LOCKED,
//   pulsing DCM_RST and retrying when lock does not return in time.
// Ports
//   CLK, RST   : clock (also the DCM PROGCLK), async active-high reset
//   req        : request channel (req_valid/req_m/req_d/req_ready)
//   PROGEN     : DCM PROGEN, registered
//   PROGDATA   : DCM PROGDATA, registered
//   PROGDONE   : from DCM, asynchronous, 2-flop synchronized
//   LOCKED     : from DCM, asynchronous, 2-flop synchronized
//   DCM_RST    : DCM reset pulse, registered
//   busy       : high outside IDLE
//   done       : one-cycle pulse at the end of every request
//   err        : 0 ok, 1 illegal M/D, 2 PROGDONE timeout, 3 lock failed
//   cur_m/d    : last successfully programmed M and D (raw)
module clkgen_prog_ctrl #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int DCM_RST_CYCLES = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    clkgen_prog_ctrl_if.slave        req,
    output logic                     PROGEN,
    output logic                     PROGDATA,
    input  logic                     PROGDONE,
    input  logic                     LOCKED,
    output logic                     DCM_RST,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err,
    output logic [8:0]               cur_m,
    output logic [8:0]               cur_d
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (DCM_RST_CYCLES < 2) ? 1 : $clog2(DCM_RST_CYCLES + 1);
    localparam int NW = (MAX_RETRIES    < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO,
        WAIT_DONE, WAIT_LOCK, DCM_RESET, FINISH
    } state_t;

    state_t          state, nstate;
    logic [3:0]      sh_cnt, nsh;
    logic [TW-1:0]   t_cnt, nt;
    logic [RW-1:0]   r_cnt, nr;
    logic [NW-1:0]   retries, nretry;
    logic [8:0]      m_lat, d_lat, nm, nd;
    logic [1:0]      nerr;
    logic [8:0]      ncur_m, ncur_d;
    logic [1:0]      done_sync, lock_sync;
    logic            done_s, lock_s;
    logic            legal;
    logic [8:0]      dm1, mm1;
    logic [9:0]      dword, mword;
    logic            pdata_n;

    assign done_s = done_sync[1];
    assign lock_s = lock_sync[1];

    assign legal = (req.req_m >= 9'd2) && (req.req_m <= 9'd256) &&
                   (req.req_d >= 9'd1) && (req.req_d <= 9'd256);

    // Next-state / datapath. All counters are reloaded on state entry and
    // stop at their terminal value, so none of them can wrap.
    always_comb begin
        nstate = state;
        nsh    = sh_cnt;
        nt     = t_cnt;
        nr     = r_cnt;
        nretry = retries;
        nm     = m_lat;
        nd     = d_lat;
        nerr   = err;
        ncur_m = cur_m;
        ncur_d = cur_d;
        case (state)
            IDLE: begin
                if (req.req_valid) begin
                    nm     = req.req_m;
                    nd     = req.req_d;
                    nerr   = 2'd0;
                    nt     = '0;
                    nr     = '0;
                    nretry = '0;
                    nsh    = '0;
                    if (legal) begin
                        nstate = LOAD_D;
                    end else begin
                        nerr   = 2'd1;
                        nstate = FINISH;
                    end
                end
            end
            LOAD_D: begin
                if (sh_cnt == 4'd9) begin nstate = GAP1; nsh = '0; end
                else nsh = sh_cnt + 4'd1;
            end
            GAP1: begin
                if (sh_cnt == 4'd1) begin nstate = LOAD_M; nsh = '0; end
                else nsh = sh_cnt + 4'd1;
            end
            LOAD_M: begin
                if (sh_cnt == 4'd9) begin nstate = GAP2; nsh = '0; end
                else nsh = sh_cnt + 4'd1;
            end
            GAP2: begin
                if (sh_cnt == 4'd1) begin nstate = GO; nsh = '0; end
                else nsh = sh_cnt + 4'd1;
            end
            GO: begin
                nstate = WAIT_DONE;
                nt     = '0;
            end
            WAIT_DONE: begin
                // A response in the last timeout cycle still wins.
                if (done_s) begin
                    nstate = WAIT_LOCK;
                    nt     = '0;
                end else if (t_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    nerr   = 2'd2;
                    nstate = FINISH;
                end else begin
                    nt = t_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    ncur_m = m_lat;
                    ncur_d = d_lat;
                    nerr   = 2'd0;
                    nstate = FINISH;
                end else if (t_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    if (retries < NW'(MAX_RETRIES)) begin
                        nstate = DCM_RESET;
                        nr     = '0;
                    end else begin
                        nerr   = 2'd3;
                        nstate = FINISH;
                    end
                end else begin
                    nt = t_cnt + 1'b1;
                end
            end
            DCM_RESET: begin
                if (r_cnt == RW'(DCM_RST_CYCLES - 1)) begin
                    nstate = WAIT_LOCK;
                    nt     = '0;
                    nretry = retries + 1'b1;
                end else begin
                    nr = r_cnt + 1'b1;
                end
            end
            FINISH:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Word layout, bit 0 shifted first: '1', command bit, then (value-1)[7:0]
    // LSB first. Built from the next-cycle latches so the first bit can be
    // registered on the acceptance edge.
    assign dm1   = nd - 9'd1;
    assign mm1   = nm - 9'd1;
    assign dword = {dm1[7:0], 1'b0, 1'b1};
    assign mword = {mm1[7:0], 1'b1, 1'b1};

    always_comb begin
        pdata_n = 1'b0;
        if (nstate == LOAD_D)      pdata_n = dword[nsh];
        else if (nstate == LOAD_M) pdata_n = mword[nsh];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            done_sync <= '0;
            lock_sync <= '0;
        end else begin
            done_sync <= {done_sync[0], PROGDONE};
            lock_sync <= {lock_sync[0], LOCKED};
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and cannot glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            sh_cnt        <= '0;
            t_cnt         <= '0;
            r_cnt         <= '0;
            retries       <= '0;
            m_lat         <= '0;
            d_lat         <= '0;
            err           <= '0;
            cur_m         <= '0;
            cur_d         <= '0;
            PROGEN        <= 1'b0;
            PROGDATA      <= 1'b0;
            DCM_RST       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            req.req_ready <= 1'b1;
        end else begin
            state         <= nstate;
            sh_cnt        <= nsh;
            t_cnt         <= nt;
            r_cnt         <= nr;
            retries       <= nretry;
            m_lat         <= nm;
            d_lat         <= nd;
            err           <= nerr;
            cur_m         <= ncur_m;
            cur_d         <= ncur_d;
            PROGEN        <= (nstate == LOAD_D) || (nstate == LOAD_M) || (nstate == GO);
            PROGDATA      <= pdata_n;
            DCM_RST       <= (nstate == DCM_RESET);
            busy          <= (nstate != IDLE);
            done          <= (nstate == FINISH);
            req.req_ready <= (nstate == IDLE);
        end
    end

endmodule

// File: tb/tb_clkgen_prog_ctrl.sv
// tb_clkgen_prog_ctrl
//   Randomized and directed requests against a cycle-level reference model
//   derived from the word format and state timing rules of the sequencer.
module tb_clkgen_prog_ctrl;
    localparam int T    = 100;
    localparam int R    = 8;
    localparam int MAXR = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PROGDONE = 1'b0;
    logic       LOCKED = 1'b0;
    logic       PROGEN, PROGDATA, DCM_RST, busy, done;
    logic [1:0] err;
    logic [8:0] cur_m, cur_d;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_m = 0;
    int exp_d = 0;

    clkgen_prog_ctrl_if bus ();

    clkgen_prog_ctrl #(
        .TIMEOUT_CYCLES (T),
        .DCM_RST_CYCLES (R),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (bus),
        .PROGEN   (PROGEN),
        .PROGDATA (PROGDATA),
        .PROGDONE (PROGDONE),
        .LOCKED   (LOCKED),
        .DCM_RST  (DCM_RST),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cur_m    (cur_m),
        .cur_d    (cur_d)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d want %0d", tag, $time, act, exp);
        end
    endtask

    // Bit i of a programming word: start bit, command bit, then (v-1) LSB first.
    function automatic logic wbit(input int v, input logic cmd, input int i);
        if (i == 0) return 1'b1;
        if (i == 1) return cmd;
        return 1'(((v - 1) >> (i - 2)) & 1);
    endfunction

    // One request starting at a negedge (cycle 0). ddly: PROGDONE rise, cycles
    // after GO (-1 = never). lafter: DCM_RST pulses before LOCKED rises
    // (-1 = never). ldly: LOCKED rise, cycles into that lock wait.
    // hold keeps req_valid high with other M/D values while busy.
    task automatic run_req(input int m, input int d, input int ddly,
                           input int ldly, input int lafter, input bit hold);
        bit         legal;
        int         done_n, e, np, ek;
        logic [1:0] xerr;
        int         old_m, old_d, new_m, new_d;
        logic       xen, xdat, xrst;

        legal = (m >= 2 && m <= 256 && d >= 1 && d <= 256);
        e = 0; np = 0; ek = 0;
        if (!legal) begin
            done_n = 1; xerr = 2'd1;
        end else if (ddly < 0) begin
            done_n = 26 + T; xerr = 2'd2;
        end else begin
            e  = 25 + ddly + 3;
            np = (lafter < 0) ? MAXR : lafter;
            ek = e + np * (T + R);
            if (lafter < 0) begin done_n = ek + T;        xerr = 2'd3; end
            else            begin done_n = ek + ldly + 3; xerr = 2'd0; end
        end
        old_m = exp_m; old_d = exp_d;
        new_m = (xerr == 2'd0) ? m : old_m;
        new_d = (xerr == 2'd0) ? d : old_d;

        bus.req_valid = 1'b1;
        bus.req_m     = 9'(m);
        bus.req_d     = 9'(d);
        PROGDONE      = 1'b0;
        LOCKED        = 1'b0;
        chk("ready_at_req", bus.req_ready, 1);

        for (int n = 1; n <= done_n + 1; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                if (hold) begin
                    bus.req_m = 9'($urandom_range(2, 256));
                    bus.req_d = 9'($urandom_range(1, 256));
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            xen  = legal && ((n >= 1 && n <= 10) || (n >= 13 && n <= 22) || n == 25);
            xdat = 1'b0;
            if (legal && n >= 1 && n <= 10)  xdat = wbit(d, 1'b0, n - 1);
            if (legal && n >= 13 && n <= 22) xdat = wbit(m, 1'b1, n - 13);
            xrst = 1'b0;
            for (int j = 0; j < np; j++)
                if (n >= e + j * (T + R) + T && n < e + j * (T + R) + T + R) xrst = 1'b1;
            chk("progen",   PROGEN,   xen);
            chk("progdata", PROGDATA, xdat);
            chk("dcm_rst",  DCM_RST,  xrst);
            chk("done",     done,     n == done_n);
            chk("busy",     busy,     n <= done_n);
            chk("ready",    bus.req_ready, n > done_n);
            chk("err",      err,      (n < done_n) ? 2'd0 : xerr);
            if (n >= done_n) begin
                chk("cur_m", cur_m, new_m);
                chk("cur_d", cur_d, new_d);
            end
            if (legal && ddly >= 0 && n == 25 + ddly) PROGDONE = 1'b1;
            if (legal && ddly >= 0 && lafter >= 0 && n == ek + ldly) LOCKED = 1'b1;
        end
        exp_m = new_m;
        exp_d = new_d;
    endtask

    initial begin
        int m, d, ddly, ldly, lafter;
        bit hold;
        bus.req_valid = 1'b0;
        bus.req_m     = '0;
        bus.req_d     = '0;

        repeat (3) @(negedge CLK);
        chk("rst_progen",  PROGEN, 0);
        chk("rst_dcm_rst", DCM_RST, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_done",    done, 0);
        chk("rst_err",     err, 0);
        chk("rst_cur_m",   cur_m, 0);
        chk("rst_cur_d",   cur_d, 0);
        chk("rst_ready",   bus.req_ready, 1);
        RST = 1'b0;
        @(negedge CLK);

        run_req(35, 8, 5, 17, 0, 1'b0);
        run_req(1, 8, 5, 10, 0, 1'b0);
        run_req(257, 256, 5, 10, 0, 1'b0);
        run_req(256, 256, 3, 4, 0, 1'b0);
        run_req(2, 1, 1, 0, 0, 1'b0);
        run_req(100, 50, -1, 0, 0, 1'b0);
        run_req(20, 10, 3, 0, -1, 1'b0);
        run_req(20, 10, 3, 5, 2, 1'b0);

        // Reset in the middle of the LoadM word.
        bus.req_valid = 1'b1;
        bus.req_m     = 9'd30;
        bus.req_d     = 9'd5;
        for (int n = 1; n <= 15; n++) begin
            @(negedge CLK);
            if (n == 1) bus.req_valid = 1'b0;
        end
        chk("pre_rst_progen", PROGEN, 1);
        RST = 1'b1;
        #1;
        chk("async_progen",  PROGEN, 0);
        chk("async_dcm_rst", DCM_RST, 0);
        chk("async_busy",    busy, 0);
        chk("async_cur_m",   cur_m, 0);
        exp_m = 0;
        exp_d = 0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", bus.req_ready, 1);
        chk("post_rst_busy",  busy, 0);

        // req_valid held through busy; the second request waits for ready.
        run_req(40, 7, 4, 6, 0, 1'b1);
        run_req(60, 9, 2, 3, 1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            m      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(2, 256));
            d      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(1, 256));
            ddly   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 30));
            ldly   = int'($urandom_range(0, 30));
            lafter = int'($urandom_range(0, 4)) - 1;
            hold   = ($urandom_range(0, 3) == 0);
            run_req(m, d, ddly, ldly, lafter, hold);
        end
        run_req(77, 13, 6, 8, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
